dragon_game_ctrl: RTL

Frame-rate game controller for the dragon runner: the parametrised successor to the single-dragon control logic. Runs the START/GAME/OVER flow, charged-jump physics with gravity, duck and fast-fall, and collision against N_OBS obstacles with a vertical extent (ground and flying). Sits between the keyboard decoder and the render engine. All outputs are registered once per frame_clk edge.

---
 rtl/game_pkg.sv | 29 ++
 rtl/obstacle_hit.sv | 35 +++
 rtl/dragon_game_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the dragon runner controller: FSM states,
// dragon action codes, default keycodes and the position width.
package game_pkg;

  localparam int POS_W = 10;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_GAME  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_t;

  typedef enum logic [2:0] {
    ACT_REST = 3'd0,
    ACT_RUN  = 3'd1,
    ACT_JUMP = 3'd2,
    ACT_DUCK = 3'd3,
    ACT_DEAD = 3'd4
  } action_t;

  localparam logic [7:0] KEY_JUMP_DEF  = 8'h20;
  localparam logic [7:0] KEY_DUCK_DEF  = 8'h26;
  localparam logic [7:0] KEY_START_DEF = 8'h0d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/obstacle_hit.sv
// Combinational overlap test of the dragon box against one obstacle slot.
// Touching edges do not count as a hit.
module obstacle_hit #(
  parameter int POS_W    = 10,
  parameter int DRAGON_X = 80,
  parameter int DRAGON_W = 10
) (
  input  logic             valid,
  input  logic [POS_W-1:0] obs_x,
  input  logic [POS_W-1:0] obs_w,
  input  logic [POS_W-1:0] obs_base,
  input  logic [POS_W-1:0] obs_h,
  input  logic [POS_W-1:0] dragon_h,
  input  logic [POS_W-1:0] cur_h,
  output logic             hit
);

  localparam int EW = POS_W + 2;
  localparam logic [EW-1:0] D_RIGHT = EW'(DRAGON_X + DRAGON_W / 2);
  localparam logic [EW-1:0] D_LEFT  = EW'(DRAGON_X - DRAGON_W / 2);

  logic [EW-1:0] half_w;
  logic [EW-1:0] x_ext;
  logic          x_ok;
  logic          y_ok;

  // X test rearranged so the obstacle's left edge never goes negative.
  assign half_w = {3'b000, obs_w[POS_W-1:1]};
  assign x_ext  = {2'b00, obs_x};
  assign x_ok   = (x_ext < D_RIGHT + half_w) && (x_ext + half_w > D_LEFT);
  assign y_ok   = ({2'b00, dragon_h} < {2'b00, obs_base} + {2'b00, obs_h}) &&
                  ({2'b00, obs_base} < {2'b00, dragon_h} + {2'b00, cur_h});
  assign hit    = valid && x_ok && y_ok;

endmodule

// File: rtl/dragon_game_ctrl.sv
// Frame-rate game controller: START/GAME/OVER flow, charged jump physics
// with gravity and fast-fall, and collision against N_OBS obstacle slots.
module dragon_game_ctrl #(
  parameter int         POS_W        = game_pkg::POS_W,
  parameter int         N_OBS        = 4,
  parameter int         DRAGON_X     = 80,
  parameter int         DRAGON_W     = 10,
  parameter int         RUN_H        = 20,
  parameter int         DUCK_H       = 10,
  parameter int         GRAVITY      = 2,
  parameter int         DUCK_GRAVITY = 2,
  parameter int         JUMP_SHORT   = 10,
  parameter int         JUMP_LONG    = 20,
  parameter int         CHARGE_THR   = 30,
  parameter int         CHARGE_MAX   = 60,
  parameter logic [7:0] KEY_JUMP     = game_pkg::KEY_JUMP_DEF,
  parameter logic [7:0] KEY_DUCK     = game_pkg::KEY_DUCK_DEF,
  parameter logic [7:0] KEY_START    = game_pkg::KEY_START_DEF
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [7:0]             keycode,
  input  logic [N_OBS-1:0]       obs_valid,
  input  logic [N_OBS*POS_W-1:0] obs_x,
  input  logic [N_OBS*POS_W-1:0] obs_w,
  input  logic [N_OBS*POS_W-1:0] obs_base,
  input  logic [N_OBS*POS_W-1:0] obs_h,
  output logic [1:0]             game_state,
  output logic [2:0]             action,
  output logic [POS_W-1:0]       dragon_h,
  output logic                   dead,
  output logic [15:0]            score
);
  import game_pkg::*;

  localparam int VW = POS_W + 2;
  localparam int CW = $clog2(CHARGE_MAX + 1);
  localparam logic signed [VW-1:0] V_ZERO  = '0;
  localparam logic signed [VW-1:0] V_GRAV  = VW'(GRAVITY);
  localparam logic signed [VW-1:0] V_DGRAV = VW'(DUCK_GRAVITY);
  localparam logic signed [VW-1:0] V_SHORT = VW'(JUMP_SHORT);
  localparam logic signed [VW-1:0] V_LONG  = VW'(JUMP_LONG);
  localparam logic [CW-1:0]        C_MAX   = CW'(CHARGE_MAX);
  localparam logic [CW-1:0]        C_THR   = CW'(CHARGE_THR);
  localparam logic [POS_W-1:0]     H_RUN   = POS_W'(RUN_H);
  localparam logic [POS_W-1:0]     H_DUCK  = POS_W'(DUCK_H);

  game_state_t             state_reg;
  action_t                 action_reg;
  logic [POS_W-1:0]        h_reg;
  logic signed [VW-1:0]    vel_reg;
  logic [CW-1:0]           charge_reg;
  logic [15:0]             score_reg;
  logic                    dead_reg;

  logic [N_OBS-1:0]        slot_hit;
  logic                    any_hit;
  logic [POS_W-1:0]        cur_h;

  logic                    key_jump;
  logic                    key_duck;
  logic                    grounded;
  logic signed [VW-1:0]    h_sum;
  logic                    lands;
  logic signed [VW-1:0]    vel_fall;
  logic signed [VW-1:0]    launch_vel;
  logic [CW-1:0]           charge_inc;
  action_t                 game_action;

  // Collision always uses the registered pose, so ducking must already be shown.
  assign cur_h = (action_reg == ACT_DUCK) ? H_DUCK : H_RUN;

  generate
    for (genvar gi = 0; gi < N_OBS; gi++) begin : g_slot
      obstacle_hit #(
        .POS_W    (POS_W),
        .DRAGON_X (DRAGON_X),
        .DRAGON_W (DRAGON_W)
      ) u_hit (
        .valid    (obs_valid[gi]),
        .obs_x    (obs_x[gi*POS_W +: POS_W]),
        .obs_w    (obs_w[gi*POS_W +: POS_W]),
        .obs_base (obs_base[gi*POS_W +: POS_W]),
        .obs_h    (obs_h[gi*POS_W +: POS_W]),
        .dragon_h (h_reg),
        .cur_h    (cur_h),
        .hit      (slot_hit[gi])
      );
    end
  endgenerate

  assign any_hit = |slot_hit;

  always_comb begin
    key_jump   = (keycode == KEY_JUMP);
    key_duck   = (keycode == KEY_DUCK);
    grounded   = (h_reg == '0) && (vel_reg == V_ZERO);
    h_sum      = $signed({2'b00, h_reg}) + vel_reg;
    lands      = h_sum[VW-1] || (h_sum == V_ZERO);
    vel_fall   = vel_reg - V_GRAV - (key_duck ? V_DGRAV : V_ZERO);
    launch_vel = (charge_reg < C_THR) ? V_SHORT : V_LONG;
    charge_inc = (charge_reg >= C_MAX) ? C_MAX : charge_reg + CW'(1);

    // Pose shown after this frame's physics update.
    if (grounded) begin
      if (!key_jump && charge_reg != '0) game_action = ACT_JUMP;
      else if (key_duck)                 game_action = ACT_DUCK;
      else                               game_action = ACT_RUN;
    end else if (lands) begin
      if (key_duck) game_action = ACT_DUCK;
      else          game_action = ACT_RUN;
    end else begin
      game_action = ACT_JUMP;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset || keycode == KEY_START) begin
      state_reg  <= ST_START;
      action_reg <= ACT_REST;
      h_reg      <= '0;
      vel_reg    <= V_ZERO;
      charge_reg <= '0;
      score_reg  <= '0;
      dead_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_START: begin
          if (key_jump) begin
            state_reg  <= ST_GAME;
            action_reg <= ACT_RUN;
          end
        end
        ST_GAME: begin
          if (any_hit) begin
            // Freeze everything, including a landing due this frame.
            state_reg  <= ST_OVER;
            action_reg <= ACT_DEAD;
            dead_reg   <= 1'b1;
          end else begin
            score_reg  <= sat_inc16(score_reg);
            action_reg <= game_action;
            if (grounded) begin
              if (key_jump) begin
                charge_reg <= charge_inc;
              end else if (charge_reg != '0) begin
                vel_reg    <= launch_vel;
                charge_reg <= '0;
              end
            end else if (lands) begin
              h_reg   <= '0;
              vel_reg <= V_ZERO;
            end else begin
              h_reg   <= h_sum[POS_W-1:0];
              vel_reg <= vel_fall;
            end
          end
        end
        ST_OVER: begin
        end
        default: begin
          state_reg  <= ST_START;
          action_reg <= ACT_REST;
          dead_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign game_state = state_reg;
  assign action     = action_reg;
  assign dragon_h   = h_reg;
  assign dead       = dead_reg;
  assign score      = score_reg;

endmodule
